// File: rtl/bram_sample_seq_if.sv
// bram_sample_seq_if: bundles the sequencer's control, BRAM read port and
// filter-side valid/ready stream. The slave modport is the sequencer view;
// the master modport is the environment (controller, BRAM, filter) view.
interface bram_sample_seq_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 101,
    parameter int LEN   = $clog2(DEPTH)
);
    logic             i_seq_start;
    logic             i_seq_stop;
    logic             o_seq_rden;
    logic [LEN-1:0]   o_seq_rdaddr;
    logic [WIDTH-1:0] i_seq_bramdata;
    logic [WIDTH-1:0] o_seq_data;
    logic             o_seq_valid;
    logic             i_seq_ready;
    logic             o_seq_busy;
    logic             o_seq_done;
    logic             o_seq_overrun;

    modport slave (
        input  i_seq_start, i_seq_stop, i_seq_bramdata, i_seq_ready,
        output o_seq_rden, o_seq_rdaddr, o_seq_data, o_seq_valid,
               o_seq_busy, o_seq_done, o_seq_overrun
    );

    modport master (
        output i_seq_start, i_seq_stop, i_seq_bramdata, i_seq_ready,
        input  o_seq_rden, o_seq_rdaddr, o_seq_data, o_seq_valid,
               o_seq_busy, o_seq_done, o_seq_overrun
    );
endinterface

// File: rtl/bram_sample_seq.sv
// bram_sample_seq: plays addresses 0..NUM_SAMPLES-1 of a sample ROM (1-cycle
// registered read) at one sample per TICK_DIV clocks and streams each word to
// the filter over valid/ready. A tick that lands while a sample is still
// waiting for acceptance sets the sticky overrun flag; the sample is kept.
// Build option SEQ_LOOP_EN: wrap to address 0 after the last sample and keep
// playing until stop (no DONE state, o_seq_done stays 0).
module bram_sample_seq #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 101,
    parameter int NUM_SAMPLES = 8,
    parameter int TICK_DIV    = 16,
    parameter int LEN         = $clog2(DEPTH)
) (
    input  logic                i_seq_clk,
    input  logic                i_seq_rstn,
    bram_sample_seq_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_READ      = 3'd2,
        S_CAPTURE   = 3'd3,
        S_OUTPUT    = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam int             CW          = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 2;
    localparam logic [CW-1:0]  TICK_RELOAD = CW'(TICK_DIV - 1);
    localparam logic [LEN-1:0] LAST_ADDR   = LEN'(NUM_SAMPLES - 1);

    state_t           state_r;
    logic [CW-1:0]    tick_cnt_r;
    logic [LEN-1:0]   addr_r;
    logic             rden_r;
    logic [LEN-1:0]   rdaddr_r;
    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             busy_r;
    logic             done_r;
    logic             overrun_r;
    logic             tick_s;
    logic             start_s;

    // Tick strobe and qualified start request.
    always_comb begin
        tick_s  = 1'b0;
        start_s = 1'b0;
        if (tick_cnt_r == {CW{1'b0}}) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if (bus.i_seq_start && !bus.i_seq_stop) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // Sample-rate counter: loaded on start, free-runs with reload while busy.
    always_ff @(posedge i_seq_clk or negedge i_seq_rstn) begin
        if (!i_seq_rstn) begin
            tick_cnt_r <= {CW{1'b0}};
        end else if (state_r == S_IDLE) begin
            if (start_s) begin
                tick_cnt_r <= TICK_RELOAD;
            end
        end else if (tick_s) begin
            tick_cnt_r <= TICK_RELOAD;
        end else begin
            tick_cnt_r <= tick_cnt_r - CW'(1'b1);
        end
    end

    // Sequencer FSM with all outputs registered; stop outranks start and ready.
    always_ff @(posedge i_seq_clk or negedge i_seq_rstn) begin
        if (!i_seq_rstn) begin
            state_r   <= S_IDLE;
            addr_r    <= {LEN{1'b0}};
            rden_r    <= 1'b0;
            rdaddr_r  <= {LEN{1'b0}};
            data_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else if ((state_r != S_IDLE) && bus.i_seq_stop) begin
            state_r <= S_IDLE;
            addr_r  <= {LEN{1'b0}};
            rden_r  <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        addr_r    <= {LEN{1'b0}};
                        overrun_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= S_WAIT_TICK;
                    end
                end
                S_WAIT_TICK: begin
                    if (tick_s) begin
                        rden_r   <= 1'b1;
                        rdaddr_r <= addr_r;
                        state_r  <= S_READ;
                    end
                end
                S_READ: begin
                    // The ROM registers its word on this edge.
                    rden_r  <= 1'b0;
                    state_r <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    data_r  <= bus.i_seq_bramdata;
                    valid_r <= 1'b1;
                    state_r <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    // A tick here is dropped; the held sample is never skipped.
                    if (tick_s) begin
                        overrun_r <= 1'b1;
                    end
                    if (bus.i_seq_ready) begin
                        valid_r <= 1'b0;
                        if (addr_r == LAST_ADDR) begin
`ifdef SEQ_LOOP_EN
                            addr_r  <= {LEN{1'b0}};
                            state_r <= S_WAIT_TICK;
`else
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
`endif
                        end else begin
                            addr_r  <= addr_r + LEN'(1'b1);
                            state_r <= S_WAIT_TICK;
                        end
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    addr_r  <= {LEN{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    addr_r  <= {LEN{1'b0}};
                    rden_r  <= 1'b0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_seq_rden    = rden_r;
    assign bus.o_seq_rdaddr  = rdaddr_r;
    assign bus.o_seq_data    = data_r;
    assign bus.o_seq_valid   = valid_r;
    assign bus.o_seq_busy    = busy_r;
    assign bus.o_seq_done    = done_r;
    assign bus.o_seq_overrun = overrun_r;

endmodule
